// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads an N x N image from ROM, applies 2x2 window commands
// around a movable origin, and streams the image to RAM on request.
module lcd_ctrl_param #(
    parameter int IMG_LOG2 = 3,
    parameter int DATA_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            cmd,
    input  logic                  cmd_valid,
    input  logic [DATA_W-1:0]     IROM_Q,
    output logic                  IROM_rd,
    output logic [2*IMG_LOG2-1:0] IROM_A,
    output logic                  IRAM_valid,
    output logic [DATA_W-1:0]     IRAM_D,
    output logic [2*IMG_LOG2-1:0] IRAM_A,
    output logic                  busy,
    output logic                  done
);
    localparam int AW   = 2 * IMG_LOG2;
    localparam int N    = 1 << IMG_LOG2;
    localparam int NPIX = 1 << AW;
    localparam logic [AW:0]         PIX_CNT = (AW+1)'(NPIX);
    localparam logic [AW:0]         CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]       LAST_A  = AW'(NPIX - 1);
    localparam logic [IMG_LOG2-1:0] O_MIN   = IMG_LOG2'(1);
    localparam logic [IMG_LOG2-1:0] O_MAX   = IMG_LOG2'(N - 1);
    localparam logic [IMG_LOG2-1:0] O_MID   = IMG_LOG2'(N / 2);

    localparam logic [3:0] CMD_WRITE = 4'd0;
    localparam logic [3:0] CMD_UP    = 4'd1;
    localparam logic [3:0] CMD_DOWN  = 4'd2;
    localparam logic [3:0] CMD_LEFT  = 4'd3;
    localparam logic [3:0] CMD_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX   = 4'd5;
    localparam logic [3:0] CMD_MIN   = 4'd6;
    localparam logic [3:0] CMD_AVG   = 4'd7;
    localparam logic [3:0] CMD_CCW   = 4'd8;
    localparam logic [3:0] CMD_CW    = 4'd9;
    localparam logic [3:0] CMD_MIRX  = 4'd10;
    localparam logic [3:0] CMD_MIRY  = 4'd11;
    localparam logic [3:0] CMD_LOAD  = 4'd12;

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t              state_r, state_s;
    logic [3:0]          cmd_r;
    logic [AW:0]         cnt_r;
    logic                cap_v_r;
    logic [AW-1:0]       cap_a_r;
    logic [IMG_LOG2-1:0] ox_r, oy_r;
    logic [DATA_W-1:0]   mem_r [NPIX];

    logic                rd_s, wr_s;
    logic [AW-1:0]       a_tl_s, a_tr_s, a_bl_s, a_br_s;
    logic [DATA_W-1:0]   tl_s, tr_s, bl_s, br_s;
    logic [DATA_W-1:0]   n_tl_s, n_tr_s, n_bl_s, n_br_s;
    logic [DATA_W+1:0]   sum_s;

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= S_LOAD;
        else        state_r <= state_s;
    end

    // Next-state decode; commands are only looked at in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_LOAD: begin
                if (cap_v_r && (cap_a_r == LAST_A)) state_s = S_IDLE;
                else                                state_s = S_LOAD;
            end
            S_IDLE: begin
                if (!cmd_valid)             state_s = S_IDLE;
                else if (cmd == CMD_WRITE)  state_s = S_WRITE;
                else if (cmd == CMD_LOAD)   state_s = S_LOAD;
                else                        state_s = S_EXEC;
            end
            S_EXEC:  state_s = S_IDLE;
            S_WRITE: begin
                if (cnt_r == PIX_CNT) state_s = S_DONE;
                else                  state_s = S_WRITE;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_LOAD;
        endcase
    end

    // Window addressing: with N a power of two, y*N+x is just {y,x}
    always_comb begin
        rd_s   = (state_r == S_LOAD)  && (cnt_r != PIX_CNT);
        wr_s   = (state_r == S_WRITE) && (cnt_r != PIX_CNT);
        a_tl_s = {oy_r - O_MIN, ox_r - O_MIN};
        a_tr_s = {oy_r - O_MIN, ox_r};
        a_bl_s = {oy_r, ox_r - O_MIN};
        a_br_s = {oy_r, ox_r};
        tl_s   = mem_r[a_tl_s];
        tr_s   = mem_r[a_tr_s];
        bl_s   = mem_r[a_bl_s];
        br_s   = mem_r[a_br_s];
    end

    // Window operation results, all taken from pre-operation values
    always_comb begin
        sum_s  = {2'b00, tl_s} + {2'b00, tr_s} + {2'b00, bl_s} + {2'b00, br_s};
        n_tl_s = tl_s;
        n_tr_s = tr_s;
        n_bl_s = bl_s;
        n_br_s = br_s;
        case (cmd_r)
            CMD_MAX: begin
                n_tl_s = max2(max2(tl_s, tr_s), max2(bl_s, br_s));
                n_tr_s = n_tl_s;
                n_bl_s = n_tl_s;
                n_br_s = n_tl_s;
            end
            CMD_MIN: begin
                n_tl_s = min2(min2(tl_s, tr_s), min2(bl_s, br_s));
                n_tr_s = n_tl_s;
                n_bl_s = n_tl_s;
                n_br_s = n_tl_s;
            end
            CMD_AVG: begin
                n_tl_s = sum_s[DATA_W+1:2];
                n_tr_s = n_tl_s;
                n_bl_s = n_tl_s;
                n_br_s = n_tl_s;
            end
            CMD_CCW: begin
                n_tl_s = tr_s; n_tr_s = br_s; n_br_s = bl_s; n_bl_s = tl_s;
            end
            CMD_CW: begin
                n_tl_s = bl_s; n_bl_s = br_s; n_br_s = tr_s; n_tr_s = tl_s;
            end
            CMD_MIRX: begin
                n_tl_s = bl_s; n_bl_s = tl_s; n_tr_s = br_s; n_br_s = tr_s;
            end
            CMD_MIRY: begin
                n_tl_s = tr_s; n_tr_s = tl_s; n_bl_s = br_s; n_br_s = bl_s;
            end
            default: begin
                n_tl_s = tl_s;
            end
        endcase
    end

    // Control registers, origin and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_r      <= 4'd0;
            cnt_r      <= {(AW+1){1'b0}};
            cap_v_r    <= 1'b0;
            cap_a_r    <= {AW{1'b0}};
            ox_r       <= O_MID;
            oy_r       <= O_MID;
            IROM_rd    <= 1'b0;
            IROM_A     <= {AW{1'b0}};
            IRAM_valid <= 1'b0;
            IRAM_D     <= {DATA_W{1'b0}};
            IRAM_A     <= {AW{1'b0}};
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            if (state_r == S_IDLE && cmd_valid) cmd_r <= cmd;
            if (state_r == S_LOAD || state_r == S_WRITE) begin
                if (cnt_r != PIX_CNT) cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= {(AW+1){1'b0}};
            end
            // ROM data arrives one cycle after its address: delay the address to match
            cap_v_r <= IROM_rd;
            cap_a_r <= IROM_A;
            IROM_rd <= rd_s;
            if (rd_s) IROM_A <= cnt_r[AW-1:0];
            IRAM_valid <= wr_s;
            if (wr_s) begin
                IRAM_A <= cnt_r[AW-1:0];
                IRAM_D <= mem_r[cnt_r[AW-1:0]];
            end
            done <= (state_r == S_WRITE) && (cnt_r == PIX_CNT);
            busy <= (state_s != S_IDLE);
            if (state_r == S_LOAD) begin
                ox_r <= O_MID;
                oy_r <= O_MID;
            end else if (state_r == S_EXEC) begin
                case (cmd_r)
                    CMD_UP:    if (oy_r != O_MIN) oy_r <= oy_r - O_MIN;
                    CMD_DOWN:  if (oy_r != O_MAX) oy_r <= oy_r + O_MIN;
                    CMD_LEFT:  if (ox_r != O_MIN) ox_r <= ox_r - O_MIN;
                    CMD_RIGHT: if (ox_r != O_MAX) ox_r <= ox_r + O_MIN;
                    default:   ox_r <= ox_r;
                endcase
            end
        end
    end

    // Image storage: ROM capture during load, window update in EXEC
    always_ff @(posedge clk) begin
        if (state_r == S_LOAD && cap_v_r) begin
            mem_r[cap_a_r] <= IROM_Q;
        end else if (state_r == S_EXEC) begin
            mem_r[a_tl_s] <= n_tl_s;
            mem_r[a_tr_s] <= n_tr_s;
            mem_r[a_bl_s] <= n_bl_s;
            mem_r[a_br_s] <= n_br_s;
        end
    end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: vector table, hand sequences, randomized commands
// against an array model, and a parameter sweep at N=4 and N=32.
module tb_lcd_ctrl_param;
    localparam int N  = 8;
    localparam int NP = 64;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, cmd_valid;
    logic [3:0] cmd;
    logic [7:0] IROM_Q, IRAM_D;
    logic       IROM_rd, IRAM_valid, busy, done;
    logic [5:0] IROM_A, IRAM_A;

    lcd_ctrl_param #(.IMG_LOG2(3), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
        .IRAM_A(IRAM_A), .busy(busy), .done(done));

    // sweep instances
    logic        sreset, svalid;
    logic [3:0]  scmd;
    logic        rd2, v2, busy2, done2, rd5, v5, busy5, done5;
    logic [3:0]  a2, ra2;
    logic [9:0]  a5, ra5;
    logic [11:0] q2, d2, q5, d5;

    lcd_ctrl_param #(.IMG_LOG2(2), .DATA_W(12)) dut2 (
        .clk(clk), .reset(sreset), .cmd(scmd), .cmd_valid(svalid), .IROM_Q(q2),
        .IROM_rd(rd2), .IROM_A(a2), .IRAM_valid(v2), .IRAM_D(d2),
        .IRAM_A(ra2), .busy(busy2), .done(done2));

    lcd_ctrl_param #(.IMG_LOG2(5), .DATA_W(12)) dut5 (
        .clk(clk), .reset(sreset), .cmd(scmd), .cmd_valid(svalid), .IROM_Q(q5),
        .IROM_rd(rd5), .IROM_A(a5), .IRAM_valid(v5), .IRAM_D(d5),
        .IRAM_A(ra5), .busy(busy5), .done(done5));

    int rom [NP];
    int img [NP];
    int got [NP];
    int ox, oy;
    int n_cmp = 0;
    int n_err = 0;

    function automatic int rom2f(input int a);
        return (a == 5 || a == 6 || a == 9 || a == 10) ? 4095 : a;
    endfunction

    function automatic int rom5f(input int a);
        return (a == 495 || a == 496 || a == 527 || a == 528) ? 4095 : a;
    endfunction

    always @(posedge clk) if (IROM_rd) IROM_Q <= 8'(rom[IROM_A]);
    always @(posedge clk) if (rd2) q2 <= 12'(rom2f(int'(a2)));
    always @(posedge clk) if (rd5) q5 <= 12'(rom5f(int'(a5)));

    int n2, nd2, n5, nd5;
    int seq2 [16];
    int seq5 [1024];
    always @(posedge clk) begin
        if (!sreset) begin
            n2 <= 0; nd2 <= 0; n5 <= 0; nd5 <= 0;
        end else begin
            if (v2) begin
                if (n2 < 16) seq2[n2] <= int'(ra2) * 4096 + int'(d2);
                n2 <= n2 + 1;
            end
            if (v5) begin
                if (n5 < 1024) seq5[n5] <= int'(ra5) * 4096 + int'(d5);
                n5 <= n5 + 1;
            end
            if (done2) nd2 <= nd2 + 1;
            if (done5) nd5 <= nd5 + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // reference model: image as a plain array, window located by row/col arithmetic
    task automatic model_reload();
        for (int a = 0; a < NP; a++) img[a] = rom[a];
        ox = N / 2;
        oy = N / 2;
    endtask

    task automatic model_apply(input int c);
        int tl, tr, bl, br, p, q, r, s, m;
        tl = (oy - 1) * N + (ox - 1); tr = tl + 1; bl = tl + N; br = bl + 1;
        p = img[tl]; q = img[tr]; r = img[bl]; s = img[br];
        case (c)
            1: if (oy > 1) oy--;
            2: if (oy < N - 1) oy++;
            3: if (ox > 1) ox--;
            4: if (ox < N - 1) ox++;
            5, 6: begin
                m = p;
                foreach (img[k]) if (k == tr || k == bl || k == br)
                    m = (c == 5) ? ((img[k] > m) ? img[k] : m) : ((img[k] < m) ? img[k] : m);
                img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m;
            end
            7: begin
                m = (p + q + r + s) / 4;
                img[tl] = m; img[tr] = m; img[bl] = m; img[br] = m;
            end
            8:  begin img[tl] = q; img[tr] = s; img[br] = r; img[bl] = p; end
            9:  begin img[tl] = r; img[bl] = s; img[br] = q; img[tr] = p; end
            10: begin img[tl] = r; img[bl] = p; img[tr] = s; img[br] = q; end
            11: begin img[tl] = q; img[tr] = p; img[bl] = s; img[br] = r; end
            12: model_reload();
            default: m = 0;
        endcase
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_wait", int'(busy), 0);
    endtask

    // called right after reset release or reload accept
    task automatic measure_load(input string nm);
        int c;
        for (c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (c == 1)      chk({nm, "_first_rd"}, int'({IROM_rd, IROM_A}), 64);
            if (c == NP)     chk({nm, "_last_rd"},  int'({IROM_rd, IROM_A}), 64 + NP - 1);
            if (c == NP + 1) chk({nm, "_rd_drop"},  int'(IROM_rd), 0);
            if (!busy) break;
        end
        chk({nm, "_latency"}, c, NP + 2);
    endtask

    task automatic send_cmd(input int c);
        wait_idle();
        cmd = 4'(c); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_accept", int'(busy), 1);
        if (c == 12) begin
            model_reload();
            measure_load("reload");
        end else begin
            model_apply(c);
            @(posedge clk); #1;
            chk("busy_exec", int'(busy), 0);
        end
    endtask

    task automatic do_write(input bit hold, input string nm);
        wait_idle();
        cmd = 4'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (hold) cmd = 4'd5;
        else      cmd_valid = 1'b0;
        chk({nm, "_busy"}, int'(busy), 1);
        for (int i = 0; i < NP; i++) begin
            @(posedge clk); #1;
            got[i] = int'(IRAM_D);
            chk({nm, "_pix"}, int'({IRAM_valid, IRAM_A, IRAM_D}), (1 << 14) | (i << 8) | img[i]);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({nm, "_done"}, int'({IRAM_valid, done, busy}), 3);
        @(posedge clk); #1;
        chk({nm, "_end"}, int'({done, busy}), 0);
    endtask

    typedef struct packed {
        logic [3:0]      c0;
        logic [3:0]      c1;
        logic [3:0][7:0] a;
        logic [3:0][7:0] v;
    } vec_t;

    function automatic vec_t mk(input int c0, input int c1,
                                input int a0, input int a1, input int a2_, input int a3,
                                input int v0, input int v1, input int v2_, input int v3);
        vec_t t;
        t.c0 = 4'(c0); t.c1 = 4'(c1);
        t.a[0] = 8'(a0); t.a[1] = 8'(a1); t.a[2] = 8'(a2_); t.a[3] = 8'(a3);
        t.v[0] = 8'(v0); t.v[1] = 8'(v1); t.v[2] = 8'(v2_); t.v[3] = 8'(v3);
        return t;
    endfunction

    vec_t tbl [12];

    initial begin
        int l2, l5;
        tbl[0]  = mk(5,  13, 27, 28, 35, 36, 36, 36, 36, 36);
        tbl[1]  = mk(7,  13, 27, 28, 35, 36, 31, 31, 31, 31);
        tbl[2]  = mk(6,  13, 27, 28, 35, 36, 27, 27, 27, 27);
        tbl[3]  = mk(10, 13, 27, 28, 35, 36, 35, 36, 27, 28);
        tbl[4]  = mk(11, 13, 27, 28, 35, 36, 28, 27, 36, 35);
        tbl[5]  = mk(8,  13, 27, 28, 35, 36, 28, 36, 27, 35);
        tbl[6]  = mk(9,  13, 27, 28, 35, 36, 35, 27, 36, 28);
        tbl[7]  = mk(14, 13, 27, 28, 35, 36, 27, 28, 35, 36);
        tbl[8]  = mk(1,  5,  19, 20, 27, 28, 28, 28, 28, 28);
        tbl[9]  = mk(4,  6,  28, 29, 36, 37, 28, 28, 28, 28);
        tbl[10] = mk(2,  11, 35, 36, 43, 44, 36, 35, 44, 43);
        tbl[11] = mk(3,  10, 26, 27, 34, 35, 34, 35, 26, 27);

        reset = 1'b0; cmd = 4'd0; cmd_valid = 1'b0;
        sreset = 1'b0; scmd = 4'd0; svalid = 1'b0;
        for (int a = 0; a < NP; a++) rom[a] = a;
        model_reload();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", int'({IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, done}), 0);
        chk("rst_busy", int'(busy), 1);
        @(negedge clk) reset = 1'b1;
        measure_load("load");
        do_write(1'b0, "wr_first");

        foreach (tbl[i]) begin
            send_cmd(12);
            send_cmd(int'(tbl[i].c0));
            send_cmd(int'(tbl[i].c1));
            do_write(1'b0, "vec");
            for (int k = 0; k < 4; k++)
                chk($sformatf("vec%0d_px%0d", i, k), got[tbl[i].a[k]], int'(tbl[i].v[k]));
        end

        // clamp at (1,1), then clockwise rotate
        send_cmd(12);
        repeat (5) send_cmd(1);
        repeat (5) send_cmd(3);
        send_cmd(9);
        do_write(1'b0, "clamp");
        chk("clamp_0", got[0], 8);
        chk("clamp_1", got[1], 0);
        chk("clamp_8", got[8], 9);
        chk("clamp_9", got[9], 1);

        send_cmd(12);
        repeat (4) send_cmd(8);
        do_write(1'b0, "ccw4");
        chk("ccw4_27", got[27], 27);
        chk("ccw4_36", got[36], 36);

        do_write(1'b1, "wr_hold");
        do_write(1'b0, "wr_repeat");
        chk("repeat_28", got[28], 28);

        // reset in the middle of a RAM stream
        wait_idle();
        cmd = 4'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (IRAM_valid && IRAM_A == 6'd20) break;
        end
        chk("mid_reach", int'(IRAM_A), 20);
        reset = 1'b0;
        #1;
        chk("mid_abort", int'({IRAM_valid, done, busy, IROM_rd}), 2);
        model_reload();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        measure_load("mid_reload");
        send_cmd(5);
        do_write(1'b0, "mid_wr");
        chk("mid_origin", got[27], 36);

        // randomized images and command streams
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < NP; a++) rom[a] = int'($urandom_range(0, 255));
            send_cmd(12);
            for (int j = 0; j < 3; j++) begin
                repeat (6) send_cmd(int'($urandom_range(1, 15)));
                do_write(1'b0, "rnd");
            end
        end

        // parameter sweep: N=4 and N=32 at 12-bit pixels
        @(negedge clk) sreset = 1'b1;
        l2 = 0; l5 = 0;
        for (int c = 1; c <= 1200; c++) begin
            @(posedge clk); #1;
            if (!busy2 && l2 == 0) l2 = c;
            if (!busy5 && l5 == 0) l5 = c;
            if (l2 != 0 && l5 != 0) break;
        end
        chk("sw2_latency", l2, 18);
        chk("sw5_latency", l5, 1026);
        scmd = 4'd7; svalid = 1'b1;
        @(posedge clk); #1;
        svalid = 1'b0;
        @(posedge clk); #1;
        scmd = 4'd0; svalid = 1'b1;
        @(posedge clk); #1;
        svalid = 1'b0;
        for (int c = 0; c < 1200 && !(nd2 == 1 && nd5 == 1); c++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sw2_count", n2, 16);
        chk("sw5_count", n5, 1024);
        chk("sw2_done", nd2, 1);
        chk("sw5_done", nd5, 1);
        for (int i = 0; i < 16; i++)   chk("sw2_pix", seq2[i], i * 4096 + rom2f(i));
        for (int i = 0; i < 1024; i++) chk("sw5_pix", seq5[i], i * 4096 + rom5f(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/lcd_ctrl_param.md
# lcd_ctrl_param

Parametrised image-window controller for the display datapath. After reset, it loads an N×N pixel image from the image ROM into internal storage. It then executes host commands on a 2×2 operation window and streams the processed image to the image RAM on request. Image size and pixel width are generic, and the block is reusable after a write: it supports repeated writes and a ROM reload command.

## Interface
- IMG_LOG2, default 3: log2 of image side N; N = 2^IMG_LOG2, allowed range 2..5.
- DATA_W, default 8: pixel width in bits.
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous active-low reset.
- cmd, input, 4: command code.
- cmd_valid, input, 1: command strobe; sampled only when busy=0.
- IROM_Q, input, DATA_W: ROM data, valid one cycle after its address.
- IROM_rd, output, 1: ROM read enable.
- IROM_A, output, 2*IMG_LOG2: ROM address.
- IRAM_valid, output, 1: RAM write strobe.
- IRAM_D, output, DATA_W: RAM write data.
- IRAM_A, output, 2*IMG_LOG2: RAM address.
- busy, output, 1: block is not accepting commands.
- done, output, 1: one-cycle pulse at the end of each write.

## Operation
- **Addressing:** pixel (row y, col x) is stored at address y*N+x.
- **Origin:** (ox, oy), each in the range 1..N-1; set to N/2 on load.
- **Window:** TL=(oy-1,ox-1), TR=(oy-1,ox), BL=(oy,ox-1), BR=(oy,ox).
- **States:** LOAD, IDLE, EXEC, WRITE, DONE.
- **LOAD:**
  - Read addresses 0..N²-1 in order, capturing IROM_Q one cycle after each address.
  - Go to IDLE once the last pixel is captured.
  - Origin is reset to (N/2, N/2).
- **IDLE:** busy=0. When cmd_valid=1, latch cmd and go to EXEC (cmd 0 → WRITE, cmd 12 → LOAD).
- **Command codes:**
  - 0: write image.
  - 1/2/3/4: shift origin up/down/left/right. Clamp at 1 and N-1; a shift at the limit is a no-op.
  - 5: max — all four window pixels take the maximum value.
  - 6: min — all four window pixels take the minimum value.
  - 7: average — all four take floor((TL+TR+BL+BR)/4), summed in DATA_W+2 bits.
  - 8: counter-clockwise rotation: TL←TR, TR←BR, BR←BL, BL←TL.
  - 9: clockwise rotation: TL←BL, BL←BR, BR←TR, TR←TL.
  - 10: mirror X: TL↔BL, TR↔BR.
  - 11: mirror Y: TL↔TR, BL↔BR.
  - 12: reload image from ROM.
  - 13–15: no-op.
- **EXEC:** perform the single-cycle operation, then return to IDLE. All four window writes use pre-operation values.
- **WRITE:**
  - Stream addresses 0..N²-1 with IRAM_valid=1, one pixel per cycle.
  - Image contents and origin are unchanged.
- **DONE:** pulse done=1 for one cycle, then return to IDLE.
- **Repeated writes:** multiple writes are legal; a second write outputs identical data if no intervening command.

## Timing
- **Reset values (while reset=0):** IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0, state=LOAD, origin=(N/2,N/2).
- **Reset mid-operation:** aborts immediately. Any partial RAM stream is discarded and a full reload starts after release.
- **Load sequence:**
  - First rising edge after release: IROM_rd=1, IROM_A=0.
  - IROM_A increments every cycle through N²-1; IROM_rd drops the cycle after IROM_A=N²-1 is presented.
  - busy falls the cycle after the last pixel is captured.
  - Load latency from reset release to busy=0 is N²+2 cycles.
- **Command accept:** a command is accepted on an edge where cmd_valid=1 and busy=0. busy=1 from the next edge onward.
- **cmd_valid while busy=1:** ignored. It is not queued.
- **Shift/ALU/no-op commands:**
  - busy is high for exactly 1 cycle.
  - Results are visible in the next write.
  - A new command may be accepted on the edge busy returns to 0.
- **Write:**
  - IRAM_valid is high for exactly N² consecutive cycles, starting the cycle after busy rises; IRAM_A runs 0..N²-1.
  - done=1 in the cycle after the final pixel, with IRAM_valid=0.
  - busy=0 the cycle after done.
- **Reload (cmd 12):** same as the reset load sequence, starting the cycle after accept; busy stays high throughout.
- **Simultaneous events:** cmd_valid is never sampled during LOAD, WRITE or DONE.

## Test plan
- **Reset and load:** N=8 with ROM[a]=a, reset released → busy=0 after 66 cycles; an immediate write streams IRAM_D=0..63 at IRAM_A=0..63, then done pulses once.
- **Max/avg:**
  - Max at (4,4) → addresses 27, 28, 35, 36 all read 36.
  - After a fresh reload, average → all four read 31 (126/4).
- **Shift clamping:** 5× up then 5× left → origin (1,1); a rotate then moves pixels 0, 1, 8, 9 per the CW mapping (write shows 8, 0, 9, 1 at 0, 1, 8, 9).
- **Mirror/CCW:**
  - Mirror X at (4,4) → 27↔35 and 28↔36 swapped.
  - CCW ×4 → image unchanged.
- **Ignored input and repeat:**
  - cmd_valid held high during a write → ignored, stream unbroken.
  - A second write → identical data and a second done pulse.
- **Reset mid-write:** reset asserted at pixel 20 → IRAM_valid=0 immediately; after release, full reload with origin (4,4).
- **Parameter sweep:** IMG_LOG2=2 and 5 with DATA_W=12 → average of 4095×4 equals 4095 with no overflow.
